// File: rtl/mips_cpu_instr_memory_pkg.sv
// Shared types and constants for the MIPS instruction memory block.
package mips_imem_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } imem_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR    = 32'h0;
  localparam logic [31:0] NOP_WORD     = 32'h0;

endpackage

// File: rtl/mips_cpu_instr_memory_loader.sv
// Program-load handshake, write pointer / word count and the LOAD/RUN(/FAULT) state machine.
// MIPS_IMEM_FAULT_LATCH_EN adds the sticky FAULT state entered on an illegal fetch.
//
// state | meaning
// LOAD  | accepting program words, CPU held
// RUN   | program loaded, CPU clocked, fetches served
// FAULT | illegal fetch seen, CPU frozen until reset
module mips_imem_loader
  import mips_imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid_i,
  input  logic          load_last_i,
`ifdef MIPS_IMEM_FAULT_LATCH_EN
  input  logic          illegal_i,
  output logic          fault_o,
`endif
  output logic          load_ready_o,
  output logic          run_o,
  output logic          we_o,
  output logic [AW-1:0] wr_idx_o,
  output logic [CW-1:0] words_loaded_o
);

  imem_state_t state_q;
  logic [CW-1:0] wr_ptr_q;
  logic [CW-1:0] words_loaded_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= LOAD;
      wr_ptr_q       <= '0;
      words_loaded_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_valid_i) begin
            wr_ptr_q       <= wr_ptr_q + 1'b1;
            words_loaded_q <= words_loaded_q + 1'b1;
            // the beat filling the last slot ends the load even without load_last
            if (load_last_i || (wr_ptr_q == CW'(DEPTH_WORDS - 1))) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
`ifdef MIPS_IMEM_FAULT_LATCH_EN
          if (illegal_i) begin
            state_q <= FAULT;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign load_ready_o   = (state_q == LOAD);
  assign run_o          = (state_q == RUN);
  assign we_o           = load_valid_i && (state_q == LOAD) && !reset;
  assign wr_idx_o       = wr_ptr_q[AW-1:0];
  assign words_loaded_o = words_loaded_q;
`ifdef MIPS_IMEM_FAULT_LATCH_EN
  assign fault_o        = (state_q == FAULT);
`endif

endmodule

// File: rtl/mips_cpu_instr_memory.sv
// Boot-region instruction memory for mips_cpu_harvard: streamed program load, then combinational fetch.
// Define MIPS_IMEM_FAULT_LATCH_EN to make an illegal fetch latch a sticky fault that freezes the CPU.
module mips_cpu_instr_memory
  import mips_imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        cpu_clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        addr_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  logic          run;
  logic          we;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] words_loaded;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:0]   diff;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          aligned;
  logic          is_halt;
  logic          illegal;

`ifdef MIPS_IMEM_FAULT_LATCH_EN
  logic fault;
`endif

  mips_imem_loader #(.DEPTH_WORDS(DEPTH_WORDS)) u_loader (
    .clk            (clk),
    .reset          (reset),
    .load_valid_i   (load_valid),
    .load_last_i    (load_last),
`ifdef MIPS_IMEM_FAULT_LATCH_EN
    .illegal_i      (illegal),
    .fault_o        (fault),
`endif
    .load_ready_o   (load_ready),
    .run_o          (run),
    .we_o           (we),
    .wr_idx_o       (wr_idx),
    .words_loaded_o (words_loaded)
  );

  // Contents survive reset; words_loaded hides anything stale.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= load_data;
    end
  end

  // Unsigned modulo difference: addresses below BASE_ADDR wrap to huge values and fail the range test.
  assign diff     = instr_address - BASE_ADDR;
  assign idx      = diff[AW+1:2];
  assign in_range = (diff < SPAN);
  assign aligned  = (instr_address[1:0] == 2'b00);
  assign is_halt  = (instr_address == HALT_ADDR);
  assign illegal  = run && !is_halt && !(in_range && aligned);

  always_comb begin
    instr_readdata = NOP_WORD;
    if (run && in_range && aligned && ({1'b0, idx} < words_loaded)) begin
      instr_readdata = mem_q[idx];
    end
  end

  assign cpu_clk_enable = run;
`ifdef MIPS_IMEM_FAULT_LATCH_EN
  assign addr_fault = fault;
`else
  assign addr_fault = illegal;
`endif

endmodule

// File: tb/tb_mips_cpu_instr_memory.sv
// Scenario bench for mips_cpu_instr_memory; expectations adapt to MIPS_IMEM_FAULT_LATCH_EN.
module tb_mips_cpu_instr_memory;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid, load_last;
  logic [31:0] load_data, instr_address;
  logic        load_ready, cpu_clk_enable, addr_fault;
  logic [31:0] instr_readdata;

  logic        lv4, ll4;
  logic [31:0] ld4, ia4;
  logic        lr4, ce4, af4;
  logic [31:0] rd4;

  int n_pass = 0;
  int n_total = 0;

  // reference model of the 256-word instance
  logic [31:0] m_mem [256];
  int          m_cnt;
  bit          m_run;

  typedef struct {
    logic [31:0] d;
    logic        f;
    string       name;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_cpu_instr_memory dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .cpu_clk_enable(cpu_clk_enable), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .addr_fault(addr_fault)
  );

  mips_cpu_instr_memory #(.DEPTH_WORDS(4)) dut4 (
    .clk(clk), .reset(reset),
    .load_valid(lv4), .load_ready(lr4), .load_data(ld4), .load_last(ll4),
    .cpu_clk_enable(ce4), .instr_address(ia4),
    .instr_readdata(rd4), .addr_fault(af4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    load_valid = 0; load_last = 0; load_data = 0; lv4 = 0; ll4 = 0; ld4 = 0;
    instr_address = BASE; ia4 = BASE;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_cnt = 0; m_run = 0;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic l, output bit acc);
    load_valid = v; load_data = d; load_last = l;
    @(negedge clk);
    chk("load_ready", {31'b0, load_ready}, {31'b0, !m_run});
    acc = v && load_ready;
    if (v && !m_run) begin
      m_mem[m_cnt] = d;
      m_cnt++;
      if (l || m_cnt == 256) m_run = 1;
    end
    @(posedge clk);
    #1 load_valid = 0; load_last = 0;
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a, input string nm);
    exp_t e;
    longint ua = longint'(a);
    longint ub = longint'(BASE);
    e.d = 32'h0; e.f = 1'b0; e.name = nm;
    if (!m_run || a == 32'h0) return e;
    if (ua < ub || ua >= ub + 1024 || (ua % 4) != 0) begin
`ifndef MIPS_IMEM_FAULT_LATCH_EN
      e.f = 1'b1;
`endif
      return e;
    end
    if ((ua - ub) / 4 < m_cnt) e.d = m_mem[int'((ua - ub) / 4)];
    return e;
  endfunction

  task automatic fetch(input string nm, input logic [31:0] a);
    exp_t e;
    sb.push_back(model_fetch(a, nm));
    instr_address = a;
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, " data"}, instr_readdata, e.d);
    chk({e.name, " fault"}, {31'b0, addr_fault}, {31'b0, e.f});
    instr_address = BASE;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 0; load_last = 0; load_data = 0; lv4 = 0; ll4 = 0; ld4 = 0;
    instr_address = BASE; ia4 = BASE;
    @(negedge clk);
    chk("rst cpu_clk_enable", {31'b0, cpu_clk_enable}, 32'd0);
    chk("rst addr_fault", {31'b0, addr_fault}, 32'd0);
    chk("rst readdata", instr_readdata, 32'd0);
    chk("rst load_ready", {31'b0, load_ready}, 32'd1);
    do_reset();
    fetch("load-state fetch", BASE);
  endtask

  task automatic test_load();
    logic [31:0] w [4] = '{32'h24420001, 32'h00000008, 32'h24420001, 32'h24000001};
    bit acc;
    int hs = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, w[i], i == 3, acc);
      hs += int'(acc);
      if (i < 3) chk("ce during load", {31'b0, cpu_clk_enable}, 32'd0);
    end
    chk("handshakes", hs, 4);
    chk("ce after last", {31'b0, cpu_clk_enable}, 32'd1);
    fetch("fetch BFC00004", 32'hBFC00004);
    fetch("fetch BFC00000", 32'hBFC00000);
    fetch("fetch BFC0000C", 32'hBFC0000C);
    fetch("fetch unloaded", 32'hBFC00010);
    beat(1'b1, 32'hDEADBEEF, 1'b0, acc);
    chk("run ignores load", {31'b0, acc}, 32'd0);
    fetch("fetch after ignored", 32'hBFC00010);
  endtask

  task automatic test_backpressure();
    logic [31:0] w [4] = '{32'h24420001, 32'h00000008, 32'h24420001, 32'h24000001};
    bit acc;
    int hs = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 32'hFFFFFFFF, 1'b1, acc);
      hs += int'(acc);
      chk("bp ce gap", {31'b0, cpu_clk_enable}, 32'd0);
      beat(1'b1, w[i], i == 3, acc);
      hs += int'(acc);
    end
    chk("bp handshakes", hs, 4);
    chk("bp ce", {31'b0, cpu_clk_enable}, 32'd1);
    for (int i = 0; i < 4; i++) fetch("bp fetch", BASE + 32'(4 * i));
  endtask

  task automatic test_full();
    int acc4 = 0;
    bit rdy [6];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      lv4 = 1'b1; ld4 = 32'h1000 + 32'(i); ll4 = 1'b0;
      @(negedge clk);
      rdy[i] = lr4;
      acc4 += int'(lr4);
      @(posedge clk);
      #1 lv4 = 1'b0;
    end
    chk("full accepted", acc4, 4);
    chk("full ready beat3", {31'b0, rdy[3]}, 32'd1);
    chk("full ready beat4", {31'b0, rdy[4]}, 32'd0);
    chk("full ce", {31'b0, ce4}, 32'd1);
    ia4 = 32'hBFC0000C;
    #1 chk("full fetch last", rd4, 32'h1003);
    ia4 = 32'hBFC00010;
    #1 chk("full fetch oob data", rd4, 32'h0);
`ifndef MIPS_IMEM_FAULT_LATCH_EN
    chk("full fetch oob fault", {31'b0, af4}, 32'd1);
`endif
    ia4 = BASE;
  endtask

  task automatic test_reset_midload();
    bit acc;
    do_reset();
    beat(1'b1, 32'hAAAA0000, 1'b0, acc);
    beat(1'b1, 32'hAAAA0001, 1'b0, acc);
    do_reset();
    beat(1'b1, 32'h11111111, 1'b0, acc);
    beat(1'b1, 32'h22222222, 1'b0, acc);
    beat(1'b1, 32'h33333333, 1'b1, acc);
    fetch("midload C", 32'hBFC0000C);
    fetch("midload 8", 32'hBFC00008);
    fetch("midload 0", 32'hBFC00000);
  endtask

  task automatic test_run_fetches();
    fetch("halt addr", 32'h00000000);
    fetch("misaligned", 32'hBFC00002);
    fetch("past end", 32'hBFC00400);
    fetch("below base", 32'hBFBFFFFC);
  endtask

  task automatic test_fault();
    instr_address = 32'hBFC00002;
    @(posedge clk);
    #1;
`ifdef MIPS_IMEM_FAULT_LATCH_EN
    chk("latch fault", {31'b0, addr_fault}, 32'd1);
    chk("latch ce", {31'b0, cpu_clk_enable}, 32'd0);
    chk("latch data", instr_readdata, 32'd0);
    instr_address = BASE;
    repeat (2) @(posedge clk);
    #1;
    chk("sticky fault", {31'b0, addr_fault}, 32'd1);
    chk("sticky ce", {31'b0, cpu_clk_enable}, 32'd0);
    chk("sticky data", instr_readdata, 32'd0);
    do_reset();
    #1 chk("fault cleared", {31'b0, addr_fault}, 32'd0);
`else
    chk("comb fault", {31'b0, addr_fault}, 32'd1);
    chk("comb ce kept", {31'b0, cpu_clk_enable}, 32'd1);
    instr_address = BASE;
    #1 chk("comb fault clear", {31'b0, addr_fault}, 32'd0);
    chk("comb data back", instr_readdata, m_mem[0]);
`endif
  endtask

  task automatic test_async_reset();
    bit acc;
    do_reset();
    beat(1'b1, 32'h0BADF00D, 1'b1, acc);
    chk("pre-async ce", {31'b0, cpu_clk_enable}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async ce", {31'b0, cpu_clk_enable}, 32'd0);
    chk("async ready", {31'b0, load_ready}, 32'd1);
    chk("async data", instr_readdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_cnt = 0; m_run = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_backpressure();
    test_full();
    test_reset_midload();
    test_run_fetches();
    test_fault();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mips_cpu_instr_memory.md
Name: mips_cpu_instr_memory

Overview:
Instruction memory that feeds instr_readdata to mips_cpu_harvard from instr_address. A program is streamed in over a valid/ready load port after reset. The CPU is held via cpu_clk_enable until loading completes. In RUN the block serves fetches combinationally from the boot region starting at BASE_ADDR, the reset vector.

Parameters:
DEPTH_WORDS, 256, number of 32-bit instruction words; power of two, at least 2
BASE_ADDR, 32'hBFC00000, byte address of word 0

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
load_valid  input  1  load word present
load_ready  output  1  block accepts a load word this cycle
load_data  input  32  instruction word to store
load_last  input  1  final word of the program (qualified by load_valid)
cpu_clk_enable  output  1  drives the CPU clk_enable; 1 only in RUN
instr_address  input  32  CPU fetch byte address
instr_readdata  output  32  fetched instruction
addr_fault  output  1  illegal fetch indicator

Behaviour:
- State machine: LOAD and RUN (plus FAULT, only under the optional feature). Reset forces LOAD.
- Counters: wr_ptr and words_loaded, each $clog2(DEPTH_WORDS)+1 bits wide.
- Reset values: state=LOAD, wr_ptr=0, words_loaded=0, cpu_clk_enable=0, addr_fault=0, instr_readdata=0.
- load_ready = (state==LOAD). Any handshake while reset is high is ignored.
- LOAD handshake (load_valid && load_ready at posedge clk):
  - mem[wr_ptr] <= load_data
  - wr_ptr++ and words_loaded++
- LOAD -> RUN on the handshake that either carries load_last=1 or writes word DEPTH_WORDS-1 (memory full).
  - cpu_clk_enable rises the first cycle after that edge.
  - On a full memory, further load beats are never accepted (ready=0).
- A cycle with load_valid=0 causes no change. load_last without load_valid is ignored.
- RUN: load_ready=0 and load inputs are ignored. State is left only by reset.
- Fetch, combinational, valid in RUN only (instr_readdata=0 in LOAD):
  - idx = (instr_address - BASE_ADDR) >> 2
  - In range (BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS), word-aligned, idx < words_loaded: readdata = mem[idx].
  - In range, aligned, idx >= words_loaded: readdata = 0 (NOP), no fault.
  - Out of range or addr[1:0]!=0: readdata = 0 and addr_fault=1.
  - Exception: instr_address == 0 (CPU halt address) returns 0 with addr_fault=0.
- Address subtraction is 32-bit modulo. The range test uses the unsigned difference < 4*DEPTH_WORDS, so no wrap aliasing is possible.
- Reset mid-load: contents are not cleared, but words_loaded=0, so no stale data is visible. Reload starts at word 0.
- Reset in RUN: returns to LOAD and cpu_clk_enable falls asynchronously.

Optional Feature:
Macro MIPS_IMEM_FAULT_LATCH_EN.
- Defined: the first illegal fetch in RUN (sampled at posedge clk) moves to FAULT.
  - addr_fault registered high and sticky.
  - cpu_clk_enable=0, freezing the CPU.
  - instr_readdata=0.
  - Cleared only by reset.
- Not defined: addr_fault is purely combinational per fetch, has no effect on cpu_clk_enable, and no FAULT state exists.

Decomposition:
- Package mips_imem_pkg holds:
  - state enum imem_state_t {LOAD, RUN, FAULT}
  - constant RESET_VECTOR = 32'hBFC00000
  - constant HALT_ADDR = 32'h0
  - NOP_WORD = 32'h0
- One natural sub-module: mips_imem_loader (handshake, wr_ptr/words_loaded counters, LOAD->RUN decision). The top holds the array and fetch decode.

Test Plan:
- Load 4 words 0x24420001, 0x00000008, 0x24420001, 0x24000001 with load_last on the 4th:
  - Exactly 4 handshakes; cpu_clk_enable=1 the next cycle.
  - Fetch BFC00004 -> 0x00000008; fetch BFC00000 -> 0x24420001.
- Backpressure: same load with load_valid gapped every other cycle -> identical contents; transition occurs only after the 4th accepted beat.
- Full: DEPTH_WORDS=4, 6 valid beats with no load_last -> 4 accepted; load_ready=0 after the 4th; RUN entered.
- Reset asserted after 2 of 4 words, then a fresh 3-word load -> fetch BFC0000C returns 0, BFC00008 returns the new 3rd word, no fault.
- RUN fetches:
  - 0x00000000 -> data 0, fault 0
  - 0xBFC00002 -> fault 1
  - 0xBFC00400 (DEPTH 256) -> fault 1
  - With MIPS_IMEM_FAULT_LATCH_EN: fault stays 1 and cpu_clk_enable=0 after the edge until reset.
